// File: rtl/truth_table_sequencer_if.sv
//==============================================================================
// Module   : truth_table_sequencer_if
// Brief    : Vector/response bus between the sequencer and a 4-input circuit.
//            Optional compare ports exist only when SEQ_COMPARE_EN is defined.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

interface truth_table_sequencer_if;
  logic        start;
  logic        y;
  logic        G;
  logic        T;
  logic        U;
  logic        E;
  logic        busy;
  logic        done;
  logic [15:0] table_out;
  logic [4:0]  ones_count;
`ifdef SEQ_COMPARE_EN
  logic        pass;
  logic [3:0]  mismatch_idx;
`endif

  modport master (
    input  start, y,
    output G, T, U, E, busy, done, table_out, ones_count
`ifdef SEQ_COMPARE_EN
    , output pass, mismatch_idx
`endif
  );

  modport slave (
    output start, y,
    input  G, T, U, E, busy, done, table_out, ones_count
`ifdef SEQ_COMPARE_EN
    , input pass, mismatch_idx
`endif
  );
endinterface

`default_nettype wire

// File: rtl/truth_table_sequencer.sv
//==============================================================================
// Module   : truth_table_sequencer
// Brief    : Sweeps {G,T,U,E} through 0..15, holding each vector DWELL cycles,
//            and captures the response y into a 16-bit truth table.
//            Optional macro SEQ_COMPARE_EN adds pass / mismatch_idx vs EXPECTED.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module truth_table_sequencer #(
  parameter int          DWELL    = 1,
  parameter logic [15:0] EXPECTED = 16'h0000
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  truth_table_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [7:0] c_dwell_last = 8'(DWELL - 1);

  state_t      r_state, w_state;
  logic [3:0]  r_idx, w_idx;
  logic [7:0]  r_dwell, w_dwell;
  logic [3:0]  r_vec, w_vec;
  logic        r_busy, w_busy;
  logic        r_done, w_done;
  logic [15:0] r_table, w_table;
  logic [4:0]  r_ones, w_ones;
`ifdef SEQ_COMPARE_EN
  logic        r_pass, w_pass;
  logic [3:0]  r_mis, w_mis;
  logic [3:0]  w_low;
  logic [15:0] w_diff;
`endif

  always_comb begin
    w_state = r_state;
    w_idx   = r_idx;
    w_dwell = r_dwell;
    w_vec   = r_vec;
    w_busy  = r_busy;
    w_done  = 1'b0;
    w_table = r_table;
    w_ones  = r_ones;
`ifdef SEQ_COMPARE_EN
    w_pass  = r_pass;
    w_mis   = r_mis;
    w_diff  = r_table ^ EXPECTED;
    w_low   = 4'd0;
    // Descending scan so the lowest differing index wins.
    for (int i = 15; i >= 0; i--) begin
      if (w_diff[i]) w_low = 4'(i);
    end
`endif
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state = S_RUN;
          w_idx   = 4'd0;
          w_dwell = 8'd0;
          w_vec   = 4'd0;
          w_table = 16'h0000;
          w_ones  = 5'd0;
          w_busy  = 1'b1;
`ifdef SEQ_COMPARE_EN
          w_pass  = 1'b0;
          w_mis   = 4'd0;
`endif
        end
      end
      S_RUN: begin
        if (r_dwell == c_dwell_last) begin
          // y is a function of the vector currently registered on G,T,U,E.
          w_table[r_idx] = bus.y;
          w_ones         = r_ones + 5'(bus.y);
          if (r_idx == 4'hF) begin
            w_state = S_DONE;
            w_busy  = 1'b0;
            w_done  = 1'b1;
            w_vec   = 4'd0;
          end else begin
            w_idx   = r_idx + 4'd1;
            w_dwell = 8'd0;
            w_vec   = r_idx + 4'd1;
          end
        end else begin
          w_dwell = r_dwell + 8'd1;
        end
      end
      S_DONE: begin
        w_state = S_IDLE;
`ifdef SEQ_COMPARE_EN
        w_pass  = (r_table == EXPECTED);
        w_mis   = w_low;
`endif
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= 4'd0;
      r_dwell <= 8'd0;
      r_vec   <= 4'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_table <= 16'h0000;
      r_ones  <= 5'd0;
`ifdef SEQ_COMPARE_EN
      r_pass  <= 1'b0;
      r_mis   <= 4'd0;
`endif
    end else begin
      r_state <= w_state;
      r_idx   <= w_idx;
      r_dwell <= w_dwell;
      r_vec   <= w_vec;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_table <= w_table;
      r_ones  <= w_ones;
`ifdef SEQ_COMPARE_EN
      r_pass  <= w_pass;
      r_mis   <= w_mis;
`endif
    end
  end

  assign bus.G          = r_vec[3];
  assign bus.T          = r_vec[2];
  assign bus.U          = r_vec[1];
  assign bus.E          = r_vec[0];
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.table_out  = r_table;
  assign bus.ones_count = r_ones;
`ifdef SEQ_COMPARE_EN
  assign bus.pass         = r_pass;
  assign bus.mismatch_idx = r_mis;
`endif

endmodule

`default_nettype wire

// File: tb/tb_truth_table_sequencer.sv
//==============================================================================
// Module   : tb_truth_table_sequencer
// Brief    : Scoreboard bench driving two sequencers (DWELL=1 and DWELL=3)
//            against truth-table functions; SEQ_COMPARE_EN adds pass checks.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_truth_table_sequencer;

  localparam logic [15:0] c_exp = 16'h0001;

  typedef struct {
    int          s;
    logic [15:0] f;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] func = 16'h0000;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  bit          mon_en = 1'b0;
  ent_t        q1[$];
  ent_t        q3[$];
  bit          lastv1 = 1'b0;
  bit          lastv3 = 1'b0;
  logic [15:0] lastf1 = 16'h0000;
  logic [15:0] lastf3 = 16'h0000;

  truth_table_sequencer_if b1();
  truth_table_sequencer_if b3();

  assign b1.y = func[{b1.G, b1.T, b1.U, b1.E}];
  assign b3.y = func[{b3.G, b3.T, b3.U, b3.E}];

  truth_table_sequencer #(.DWELL(1), .EXPECTED(c_exp)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1.master));
  truth_table_sequencer #(.DWELL(3), .EXPECTED(c_exp)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .bus(b3.master));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] low_mis(input logic [15:0] f);
    logic [15:0] d;
    d = f ^ c_exp;
    low_mis = 4'd0;
    for (int i = 15; i >= 0; i--) if (d[i]) low_mis = 4'(i);
  endfunction

  // Reference: vector k-1/d shown during cycle k of a sweep, done at 16*d+1,
  // table equals the function under test, ones is its population count.
  task automatic mon(input string nm, input int d, input logic bsy, input logic dn,
                     input logic [3:0] vec, input logic [15:0] tbl, input logic [4:0] ones,
                     input bit have, input int s, input logic [15:0] f,
                     input bit lv, input logic [15:0] lf, output bit pop);
    int k;
    pop = 1'b0;
    if (!have) begin
      chk({nm, " idle_busy"}, 32'(bsy), 32'd0);
      chk({nm, " idle_done"}, 32'(dn), 32'd0);
      chk({nm, " idle_vec"}, 32'(vec), 32'd0);
      chk({nm, " hold_table"}, 32'(tbl), lv ? 32'(lf) : 32'd0);
      chk({nm, " hold_ones"}, 32'(ones), lv ? 32'($countones(lf)) : 32'd0);
    end else begin
      k = cyc - s;
      chk({nm, " busy"}, 32'(bsy), 32'(k >= 1 && k <= 16 * d));
      chk({nm, " vec"}, 32'(vec), (k >= 1 && k <= 16 * d) ? 32'((k - 1) / d) : 32'd0);
      chk({nm, " done"}, 32'(dn), 32'(k == 16 * d + 1));
      if (k >= 16 * d + 1) begin
        chk({nm, " table"}, 32'(tbl), 32'(f));
        chk({nm, " ones"}, 32'(ones), 32'($countones(f)));
        pop = 1'b1;
      end
    end
  endtask

  always @(negedge clk) begin
    bit p;
    if (mon_en) begin
`ifdef SEQ_COMPARE_EN
      if (q1.size() == 0) begin
        chk("d1 pass", 32'(b1.pass), 32'(lastv1 && lastf1 == c_exp));
        chk("d1 mis", 32'(b1.mismatch_idx), lastv1 ? 32'(low_mis(lastf1)) : 32'd0);
      end
      if (q3.size() == 0) begin
        chk("d3 pass", 32'(b3.pass), 32'(lastv3 && lastf3 == c_exp));
        chk("d3 mis", 32'(b3.mismatch_idx), lastv3 ? 32'(low_mis(lastf3)) : 32'd0);
      end
`endif
      mon("d1", 1, b1.busy, b1.done, {b1.G, b1.T, b1.U, b1.E}, b1.table_out, b1.ones_count,
          q1.size() > 0, q1.size() > 0 ? q1[0].s : 0, q1.size() > 0 ? q1[0].f : 16'h0,
          lastv1, lastf1, p);
      if (p) begin lastv1 = 1'b1; lastf1 = q1[0].f; void'(q1.pop_front()); end
      mon("d3", 3, b3.busy, b3.done, {b3.G, b3.T, b3.U, b3.E}, b3.table_out, b3.ones_count,
          q3.size() > 0, q3.size() > 0 ? q3[0].s : 0, q3.size() > 0 ? q3[0].f : 16'h0,
          lastv3, lastf3, p);
      if (p) begin lastv3 = 1'b1; lastf3 = q3[0].f; void'(q3.pop_front()); end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q1.size() != 0 || q3.size() != 0) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk("sweep_timeout", 32'(q1.size() + q3.size()), 32'd0);
    q1.delete();
    q3.delete();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [15:0] f);
    func = f;
    @(posedge clk); #1;
    b1.start = 1'b1;
    b3.start = 1'b1;
    q1.push_back('{cyc, f});
    q3.push_back('{cyc, f});
    @(posedge clk); #1;
    b1.start = 1'b0;
    b3.start = 1'b0;
  endtask

  task automatic wait_vec(input logic [3:0] v);
    int n;
    n = 0;
    while ({b1.G, b1.T, b1.U, b1.E} != v && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reach_vector", 32'(n < 40), 32'd1);
  endtask

  task automatic sweep(input logic [15:0] f, input bit repulse);
    issue(f);
    if (repulse) begin
      wait_vec(4'd7);
      b1.start = 1'b1;
      b3.start = 1'b1;
      @(posedge clk); #1;
      b1.start = 1'b0;
      b3.start = 1'b0;
    end
    wait_idle();
  endtask

  initial begin
    b1.start = 1'b0;
    b3.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b1;
    rst_n = 1'b1;
    sweep(16'hF000, 1'b0);          // y = G & T
    sweep(16'hFFFF, 1'b0);          // y tied 1
    sweep(16'h0001, 1'b0);          // y = ~(G|T|U|E)
    sweep(16'h0000, 1'b0);          // y tied 0
    sweep(16'(~$urandom), 1'b1);    // start re-pulsed on vector 7

    // Abort mid-sweep on vector 5; no done, no partial table afterwards.
    issue(16'($urandom));
    wait_vec(4'd5);
    rst_n = 1'b0;
    @(posedge clk); #1;
    q1.delete();
    q3.delete();
    lastv1 = 1'b0;
    lastv3 = 1'b0;
    rst_n = 1'b1;
    chk("rst d1 table", 32'(b1.table_out), 32'd0);
    chk("rst d1 busy", 32'(b1.busy), 32'd0);
    chk("rst d3 ones", 32'(b3.ones_count), 32'd0);
    chk("rst d3 vec", 32'({b3.G, b3.T, b3.U, b3.E}), 32'd0);

    for (int i = 0; i < 6; i++) sweep(16'($urandom), 1'b0);
    repeat (100) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
